// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Index i holds the pattern for hex digit i (0..9, A, b, C, d, E, F).
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {BLANK, DRIVE} phase_e;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        lz;
    } disp_set_t;

endpackage

// File: rtl/seg7_scan_controller_if.sv
// Display-content load channel between user logic (master) and the scan controller (slave).
interface seg7_scan_controller_if;

    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  en_in;
    logic        lz_in;
    logic        load;
    logic        load_ack;

    modport master (
        output digits_in, dp_in, en_in, lz_in, load,
        input  load_ack
    );

    modport slave (
        input  digits_in, dp_in, en_in, lz_in, load,
        output load_ack
    );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg7_scan_controller.sv
// Four-digit multiplexed seven-segment scanner with blanking, leading-zero suppression
// and frame-synchronous loading of new display contents.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    seg7_scan_controller_if.slave   bus,
    output logic                    frame_start,
    output logic [3:0]              an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    phase_e           phase_q, phase_d;
    logic             armed_q;
    logic             pending_q, pending_d;
    disp_set_t        shadow_q, shadow_d;
    disp_set_t        active_q, active_d;
    logic             frame_start_q, boundary_d;
    logic             ack_q, ack_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    disp_set_t        in_set;
    logic [3:0]       vis;
    logic             lead;
    logic [3:0]       nib;
    logic [6:0]       dec_seg;

    assign in_set = {bus.digits_in, bus.dp_in, bus.en_in, bus.lz_in};

    // Counter holds at 0 for one cycle after reset so that cycle is slot 0, cycle 0.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (armed_q) begin
            if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
                cnt_d = '0;
                idx_d = idx_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        boundary_d = (cnt_d == '0) && (idx_d == 2'd0);

        phase_d = phase_q;
        unique case (phase_q)
            BLANK: if (cnt_d == CNT_W'(BLANK_CYCLES)) phase_d = DRIVE;
            DRIVE: if (cnt_d == '0) phase_d = BLANK;
        endcase
    end

    // frame_start_q marks the current cycle as the frame boundary.
    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        active_d  = active_q;
        ack_d     = 1'b0;
        if (bus.load) begin
            shadow_d  = in_set;
            pending_d = 1'b1;
        end
        if (frame_start_q && bus.load) begin
            active_d  = in_set;
            pending_d = 1'b0;
        end
        if (boundary_d && pending_d) begin
            active_d  = shadow_d;
            pending_d = 1'b0;
            ack_d     = 1'b1;
        end
    end

    assign nib = active_d.digits[{idx_d, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .hex (nib),
        .seg (dec_seg)
    );

    // Outputs are computed from next-state values so they line up with cnt_q.
    always_comb begin
        vis  = active_d.en;
        lead = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (active_d.lz && lead && (active_d.digits[4*i +: 4] == 4'h0)) vis[i] = 1'b0;
            lead = lead && ((active_d.digits[4*i +: 4] == 4'h0) || !active_d.en[i]);
        end

        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if ((phase_d == DRIVE) && vis[idx_d]) begin
            an_d[idx_d] = 1'b0;
            seg_d       = dec_seg;
            dp_d        = ~active_d.dp[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= 2'd0;
            phase_q       <= BLANK;
            armed_q       <= 1'b0;
            pending_q     <= 1'b0;
            shadow_q      <= '0;
            active_q      <= '0;
            frame_start_q <= 1'b0;
            ack_q         <= 1'b0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            phase_q       <= phase_d;
            armed_q       <= 1'b1;
            pending_q     <= pending_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            frame_start_q <= boundary_d;
            ack_q         <= ack_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    // A load landing on the boundary cycle itself is acknowledged in that cycle.
    assign bus.load_ack = ack_q | (frame_start_q & bus.load);
    assign frame_start  = frame_start_q;
    assign an           = an_q;
    assign seg          = seg_q;
    assign dp           = dp_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed, table-driven bench for seg7_scan_controller with REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seg7_scan_controller;

    logic       clk;
    logic       rst;
    logic       frame_start;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    seg7_scan_controller_if bus ();

    seg7_scan_controller #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .frame_start (frame_start),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    typedef struct {
        int          cyc;
        logic        ld;
        logic [15:0] d;
        logic [3:0]  dpv;
        logic [3:0]  env;
        logic        lz;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        fs;
        logic        ack;
    } vec_t;

    vec_t vecs[$];
    int   ack_log[$];
    int   cyc;
    int   pass;
    int   total;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (!rst && bus.load_ack === 1'b1) ack_log.push_back(cyc);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        cyc++;
    endtask

    task automatic add(input int c, input logic ld, input logic [15:0] d, input logic [3:0] dpv,
                       input logic [3:0] env, input logic lz, input logic [3:0] a,
                       input logic [6:0] s, input logic p, input logic fs, input logic ack);
        vec_t v;
        v.cyc = c; v.ld = ld; v.d = d; v.dpv = dpv; v.env = env; v.lz = lz;
        v.an = a; v.seg = s; v.dp = p; v.fs = fs; v.ack = ack;
        vecs.push_back(v);
    endtask

    initial begin
        bit dark_ok;
        int expect_acks[5] = '{32, 96, 128, 192, 224};

        pass = 0;
        total = 0;
        cyc = 0;
        rst = 1'b1;
        bus.load = 1'b0;
        bus.digits_in = '0;
        bus.dp_in = '0;
        bus.en_in = '0;
        bus.lz_in = 1'b0;

        // Reset, then 1234 loaded at cycle 5 shows from frame 1.
        add(0,   0, 16'h0, 4'h0, 4'h0, 0, 4'hF, 7'h7F, 1, 1, 0);
        add(5,   1, 16'h1234, 4'b0001, 4'hF, 0, 4'hF, 7'h7F, 1, 0, 0);
        add(16,  0, 16'h0, 4'h0, 4'h0, 0, 4'hF, 7'h7F, 1, 0, 0);
        add(31,  0, 16'h0, 4'h0, 4'h0, 0, 4'hF, 7'h7F, 1, 0, 0);
        add(32,  0, 16'h0, 4'h0, 4'h0, 0, 4'hF, 7'h7F, 1, 1, 1);
        add(33,  0, 16'h0, 4'h0, 4'h0, 0, 4'hF, 7'h7F, 1, 0, 0);
        add(34,  0, 16'h0, 4'h0, 4'h0, 0, 4'b1110, 7'h19, 0, 0, 0);
        add(39,  0, 16'h0, 4'h0, 4'h0, 0, 4'b1110, 7'h19, 0, 0, 0);
        add(40,  0, 16'h0, 4'h0, 4'h0, 0, 4'hF, 7'h7F, 1, 0, 0);
        add(42,  0, 16'h0, 4'h0, 4'h0, 0, 4'b1101, 7'h30, 1, 0, 0);
        add(50,  0, 16'h0, 4'h0, 4'h0, 0, 4'b1011, 7'h24, 1, 0, 0);
        add(58,  0, 16'h0, 4'h0, 4'h0, 0, 4'b0111, 7'h79, 1, 0, 0);
        add(63,  0, 16'h0, 4'h0, 4'h0, 0, 4'b0111, 7'h79, 1, 0, 0);
        add(64,  0, 16'h0, 4'h0, 4'h0, 0, 4'hF, 7'h7F, 1, 1, 0);
        // Leading-zero blanking: 0040 then 0000.
        add(65,  1, 16'h0040, 4'h0, 4'hF, 1, 4'hF, 7'h7F, 1, 0, 0);
        add(96,  0, 16'h0, 4'h0, 4'h0, 0, 4'hF, 7'h7F, 1, 1, 1);
        add(98,  0, 16'h0, 4'h0, 4'h0, 0, 4'b1110, 7'h40, 1, 0, 0);
        add(100, 1, 16'h0000, 4'h0, 4'hF, 1, 4'b1110, 7'h40, 1, 0, 0);
        add(106, 0, 16'h0, 4'h0, 4'h0, 0, 4'b1101, 7'h19, 1, 0, 0);
        add(114, 0, 16'h0, 4'h0, 4'h0, 0, 4'hF, 7'h7F, 1, 0, 0);
        add(122, 0, 16'h0, 4'h0, 4'h0, 0, 4'hF, 7'h7F, 1, 0, 0);
        add(128, 0, 16'h0, 4'h0, 4'h0, 0, 4'hF, 7'h7F, 1, 1, 1);
        add(130, 0, 16'h0, 4'h0, 4'h0, 0, 4'b1110, 7'h40, 1, 0, 0);
        add(138, 0, 16'h0, 4'h0, 4'h0, 0, 4'hF, 7'h7F, 1, 0, 0);
        add(146, 0, 16'h0, 4'h0, 4'h0, 0, 4'hF, 7'h7F, 1, 0, 0);
        add(154, 0, 16'h0, 4'h0, 4'h0, 0, 4'hF, 7'h7F, 1, 0, 0);
        // Overwrite: AAAA then 5555, last wins.
        add(165, 1, 16'hAAAA, 4'h0, 4'hF, 0, 4'b1110, 7'h40, 1, 0, 0);
        add(170, 1, 16'h5555, 4'h0, 4'hF, 0, 4'hF, 7'h7F, 1, 0, 0);
        add(192, 0, 16'h0, 4'h0, 4'h0, 0, 4'hF, 7'h7F, 1, 1, 1);
        add(194, 0, 16'h0, 4'h0, 4'h0, 0, 4'b1110, 7'h12, 1, 0, 0);
        add(202, 0, 16'h0, 4'h0, 4'h0, 0, 4'b1101, 7'h12, 1, 0, 0);
        add(210, 0, 16'h0, 4'h0, 4'h0, 0, 4'b1011, 7'h12, 1, 0, 0);
        add(218, 0, 16'h0, 4'h0, 4'h0, 0, 4'b0111, 7'h12, 1, 0, 0);
        // Load exactly on the boundary cycle bypasses into the active set.
        add(224, 1, 16'h8888, 4'h0, 4'hF, 0, 4'hF, 7'h7F, 1, 1, 1);
        add(226, 0, 16'h0, 4'h0, 4'h0, 0, 4'b1110, 7'h00, 1, 0, 0);
        add(234, 0, 16'h0, 4'h0, 4'h0, 0, 4'b1101, 7'h00, 1, 0, 0);
        add(242, 0, 16'h0, 4'h0, 4'h0, 0, 4'b1011, 7'h00, 1, 0, 0);
        add(250, 0, 16'h0, 4'h0, 4'h0, 0, 4'b0111, 7'h00, 1, 0, 0);
        add(256, 0, 16'h0, 4'h0, 4'h0, 0, 4'hF, 7'h7F, 1, 1, 0);

        repeat (3) tick();
        @(negedge clk);
        check("reset an", 16'(an), 16'hF);
        check("reset seg", 16'(seg), 16'h7F);
        check("reset dp", 16'(dp), 16'h1);
        check("reset load_ack", 16'(bus.load_ack), 16'h0);
        check("reset frame_start", 16'(frame_start), 16'h0);

        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;
        ack_log.delete();

        for (int i = 0; i < vecs.size(); i++) begin
            while (cyc < vecs[i].cyc) tick();
            if (vecs[i].ld) begin
                bus.digits_in = vecs[i].d;
                bus.dp_in     = vecs[i].dpv;
                bus.en_in     = vecs[i].env;
                bus.lz_in     = vecs[i].lz;
                bus.load      = 1'b1;
            end
            @(negedge clk);
            check("an", 16'(an), 16'(vecs[i].an));
            check("seg", 16'(seg), 16'(vecs[i].seg));
            check("dp", 16'(dp), 16'(vecs[i].dp));
            check("frame_start", 16'(frame_start), 16'(vecs[i].fs));
            check("load_ack", 16'(bus.load_ack), 16'(vecs[i].ack));
        end

        check("ack count", 16'(ack_log.size()), 16'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < ack_log.size()) check("ack cycle", 16'(ack_log[i]), 16'(expect_acks[i]));
        end

        // Reset during DRIVE of slot 2 with a load pending.
        tick();
        bus.digits_in = 16'h1111;
        bus.dp_in     = 4'hF;
        bus.en_in     = 4'hF;
        bus.lz_in     = 1'b0;
        bus.load      = 1'b1;
        while (cyc < 275) tick();
        @(negedge clk);
        check("pre-reset slot2 an", 16'(an), 16'(4'b1011));
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("mid reset an", 16'(an), 16'hF);
        check("mid reset seg", 16'(seg), 16'h7F);
        check("mid reset dp", 16'(dp), 16'h1);
        check("mid reset load_ack", 16'(bus.load_ack), 16'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;
        ack_log.delete();
        @(negedge clk);
        check("post reset frame_start", 16'(frame_start), 16'h1);
        dark_ok = 1'b1;
        while (cyc < 40) begin
            tick();
            @(negedge clk);
            if (an !== 4'hF) dark_ok = 1'b0;
            if (cyc == 32) check("post reset frame_start 32", 16'(frame_start), 16'h1);
            if (cyc == 16) check("post reset frame_start 16", 16'(frame_start), 16'h0);
        end
        check("post reset dark", 16'(dark_ok), 16'h1);
        check("post reset no ack", 16'(ack_log.size()), 16'd0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
